hwk2_exhaustive_checker: RTL and testbench

Self-running stimulus-and-check stage for the three-input, two-output combinational homework blocks (inputs A, B, C; outputs F and its simplified form Fs). On a start pulse it drives all eight input combinations in ascending order 000 to 111, with A as the MSB. It samples F and Fs once per pattern and compares both against a parameterised expected truth table. It reports an error count, the first failing pattern and pass/done status, so synthesized and simulated benches need no hand-written stimulus.

---
 rtl/hwk2_exhaustive_checker.sv | 118 +++++++++++
 tb/tb_hwk2_exhaustive_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwk2_exhaustive_checker.sv
// Exhaustive stimulus-and-check stage for a 3-input, 2-output combinational block.
// Steps {A,B,C} through 000..111, holds each pattern SETTLE_CYCLES cycles, then
// samples F/Fs and scores them against the TRUTH table (bit i = expected output
// for pattern i). Results stay visible in DONE until the next start or reset.
//
// state | meaning
// IDLE  | after reset, stimulus parked at 000, waiting for start
// RUN   | driving pattern idx, counting down the hold before sampling
// DONE  | all eight patterns scored, results held, stimulus parked at 111
module hwk2_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  TRUTH         = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       F,
  input  logic       Fs,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       fail_seen,
  output logic [7:0] f_obs,
  output logic [7:0] fs_obs
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Hold counter reload; SETTLE_CYCLES is limited to 1..15 so this fits 4 bits.
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] idx;
  logic [3:0] hold_cnt;
  logic       launch;
  logic       sample;
  logic       mismatch;

  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign sample   = (state == RUN) && (hold_cnt == 4'd0);
  assign mismatch = (F != TRUTH[idx]) || (Fs != TRUTH[idx]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (sample && (idx == 3'd7)) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Pattern index, hold counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 3'd0;
      hold_cnt   <= 4'd0;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fail_seen  <= 1'b0;
      f_obs      <= 8'h00;
      fs_obs     <= 8'h00;
    end else if (launch) begin
      idx        <= 3'd0;
      hold_cnt   <= RELOAD;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fail_seen  <= 1'b0;
      f_obs      <= 8'h00;
      fs_obs     <= 8'h00;
    end else if (state == RUN) begin
      if (sample) begin
        f_obs[idx]  <= F;
        fs_obs[idx] <= Fs;
        if (mismatch) begin
          // One count per pattern, even when both outputs disagree.
          err_count <= err_count + 4'd1;
          if (!fail_seen) begin
            first_fail <= idx;
            fail_seen  <= 1'b1;
          end
        end
        // Pattern 7 stays on the pins after the run so DONE shows 111.
        if (idx != 3'd7) begin
          idx      <= idx + 3'd1;
          hold_cnt <= RELOAD;
        end
      end else begin
        hold_cnt <= hold_cnt - 4'd1;
      end
    end
  end

  // Status outputs decoded from registered state only; F/Fs never reach them directly.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    pass      = (state == DONE) && (err_count == 4'd0);
    {A, B, C} = idx;
  end

endmodule

// File: tb/tb_hwk2_exhaustive_checker.sv
// Bench for hwk2_exhaustive_checker: three instances with different hold lengths
// and truth tables, a cycle-by-cycle reference model and a few literal pins.
module tb_hwk2_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_v;
  logic [2:0]      start_v;
  logic [2:0]      f_v;
  logic [2:0]      fs_v;
  logic [2:0]      a_v, b_v, c_v;
  logic [2:0]      busy_v, done_v, pass_v, seen_v;
  logic [2:0][3:0] err_v;
  logic [2:0][2:0] ff_v;
  logic [2:0][7:0] fo_v, fso_v;

  // Model state per instance: run active, start edge, and how F/Fs are driven.
  // mode 0 = correct output from the truth table, 1 = stuck at 0, 2 = stuck at 1.
  bit       st[3];
  int       t0[3];
  logic [1:0] fmode[3];
  logic [1:0] fsmode[3];

  int cyc = 0;
  bit cmp_en = 1'b0;
  int checks = 0;
  int failures = 0;

  function automatic int settle_of(int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic logic [7:0] truth_of(int i);
    case (i)
      0:       return 8'hE8;
      1:       return 8'h96;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic fn(logic [1:0] m, logic [7:0] tr, int p);
    logic [2:0] pi;
    pi = p[2:0];
    case (m)
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return tr[pi];
    endcase
  endfunction

  hwk2_exhaustive_checker #(.SETTLE_CYCLES(1), .TRUTH(8'hE8)) u_maj (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .F(f_v[0]), .Fs(fs_v[0]),
    .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .first_fail(ff_v[0]),
    .fail_seen(seen_v[0]), .f_obs(fo_v[0]), .fs_obs(fso_v[0]));

  hwk2_exhaustive_checker #(.SETTLE_CYCLES(3), .TRUTH(8'h96)) u_xor (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .F(f_v[1]), .Fs(fs_v[1]),
    .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .first_fail(ff_v[1]),
    .fail_seen(seen_v[1]), .f_obs(fo_v[1]), .fs_obs(fso_v[1]));

  hwk2_exhaustive_checker #(.SETTLE_CYCLES(1), .TRUTH(8'h01)) u_nor (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .F(f_v[2]), .Fs(fs_v[2]),
    .A(a_v[2]), .B(b_v[2]), .C(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .first_fail(ff_v[2]),
    .fail_seen(seen_v[2]), .f_obs(fo_v[2]), .fs_obs(fso_v[2]));

  // Combinational blocks under test, driven from each instance's stimulus.
  always_comb begin
    f_v  = '0;
    fs_v = '0;
    for (int i = 0; i < 3; i++) begin
      f_v[i]  = fn(fmode[i],  truth_of(i), int'({a_v[i], b_v[i], c_v[i]}));
      fs_v[i] = fn(fsmode[i], truth_of(i), int'({a_v[i], b_v[i], c_v[i]}));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs derived from elapsed cycles since the start edge.
  task automatic check_inst(input int i);
    logic [2:0] e_idx;
    logic       e_busy, e_done, e_pass, e_seen;
    logic [3:0] e_err;
    logic [2:0] e_ff;
    logic [7:0] e_fo, e_fso, tr;
    logic       fo, fso;
    int         k, n, s;
    e_idx = 3'd0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_seen = 1'b0;
    e_err = 4'd0; e_ff = 3'd0; e_fo = 8'h00; e_fso = 8'h00;
    if (st[i]) begin
      s  = settle_of(i);
      tr = truth_of(i);
      k  = cyc - t0[i];
      n  = k / s;
      if (n > 8) n = 8;
      e_idx  = 3'((n > 7) ? 7 : n);
      e_busy = (n < 8);
      e_done = (n == 8);
      for (int p = 0; p < n; p++) begin
        fo  = fn(fmode[i], tr, p);
        fso = fn(fsmode[i], tr, p);
        e_fo[p]  = fo;
        e_fso[p] = fso;
        if ((fo != tr[p]) || (fso != tr[p])) begin
          if (!e_seen) begin
            e_seen = 1'b1;
            e_ff   = 3'(p);
          end
          e_err = e_err + 4'd1;
        end
      end
      e_pass = e_done && (e_err == 4'd0);
    end
    chk($sformatf("u%0d_abc@%0d", i, cyc), 8'({a_v[i], b_v[i], c_v[i]}), 8'(e_idx));
    chk($sformatf("u%0d_busy@%0d", i, cyc), 8'(busy_v[i]), 8'(e_busy));
    chk($sformatf("u%0d_done@%0d", i, cyc), 8'(done_v[i]), 8'(e_done));
    chk($sformatf("u%0d_pass@%0d", i, cyc), 8'(pass_v[i]), 8'(e_pass));
    chk($sformatf("u%0d_err@%0d", i, cyc), 8'(err_v[i]), 8'(e_err));
    chk($sformatf("u%0d_first_fail@%0d", i, cyc), 8'(ff_v[i]), 8'(e_ff));
    chk($sformatf("u%0d_fail_seen@%0d", i, cyc), 8'(seen_v[i]), 8'(e_seen));
    chk($sformatf("u%0d_f_obs@%0d", i, cyc), fo_v[i], e_fo);
    chk($sformatf("u%0d_fs_obs@%0d", i, cyc), fso_v[i], e_fso);
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) check_inst(i);
    end
  end

  // Pulse start for one cycle; the model only takes it when the DUT would.
  task automatic pulse_start(input int i, input logic [1:0] fm, input logic [1:0] fsm);
    @(negedge clk);
    if (!(st[i] && ((cyc + 1 - t0[i]) <= 8 * settle_of(i)))) begin
      st[i]     = 1'b1;
      t0[i]     = cyc + 1;
      fmode[i]  = fm;
      fsmode[i] = fsm;
    end
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int c;
    c = 0;
    while (!done_v[i] && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("u%0d_done_wait", i), 8'(done_v[i]), 8'd1);
  endtask

  initial begin
    rst_v   = 3'b111;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; t0[i] = 0; fmode[i] = 2'd0; fsmode[i] = 2'd0;
    end
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst_v = 3'b000;
    chk("reset_err", 8'(err_v[0]), 8'd0);
    chk("reset_fobs", fo_v[0], 8'h00);

    // Majority, all correct, with an ignored start mid-run.
    pulse_start(0, 2'd0, 2'd0);
    repeat (2) @(negedge clk);
    pulse_start(0, 2'd1, 2'd1);
    wait_done(0);
    chk("maj_done_at", 8'(cyc - t0[0]), 8'd8);
    chk("maj_err", 8'(err_v[0]), 8'd0);
    chk("maj_pass", 8'(pass_v[0]), 8'd1);
    chk("maj_seen", 8'(seen_v[0]), 8'd0);
    chk("maj_fobs", fo_v[0], 8'hE8);
    chk("maj_fsobs", fso_v[0], 8'hE8);

    // Fs stuck at 0.
    pulse_start(0, 2'd0, 2'd1);
    wait_done(0);
    chk("fs0_err", 8'(err_v[0]), 8'd4);
    chk("fs0_first", 8'(ff_v[0]), 8'd3);
    chk("fs0_seen", 8'(seen_v[0]), 8'd1);
    chk("fs0_pass", 8'(pass_v[0]), 8'd0);
    chk("fs0_fsobs", fso_v[0], 8'h00);
    chk("fs0_fobs", fo_v[0], 8'hE8);

    // Restart from DONE with F forced to 1.
    pulse_start(0, 2'd2, 2'd0);
    wait_done(0);
    chk("f1_err", 8'(err_v[0]), 8'd4);
    chk("f1_first", 8'(ff_v[0]), 8'd0);
    chk("f1_fobs", fo_v[0], 8'hFF);

    // Reset while pattern 100 is on the pins, then a clean run.
    pulse_start(0, 2'd0, 2'd0);
    repeat (4) @(negedge clk);
    chk("mid_abc", 8'({a_v[0], b_v[0], c_v[0]}), 8'd4);
    rst_v[0] = 1'b1;
    st[0]    = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("rst_busy", 8'(busy_v[0]), 8'd0);
    chk("rst_fobs", fo_v[0], 8'h00);
    pulse_start(0, 2'd0, 2'd0);
    wait_done(0);
    chk("post_rst_done_at", 8'(cyc - t0[0]), 8'd8);
    chk("post_rst_pass", 8'(pass_v[0]), 8'd1);

    // XOR with three-cycle hold.
    pulse_start(1, 2'd0, 2'd0);
    wait_done(1);
    chk("xor_done_at", 8'(cyc - t0[1]), 8'd24);
    chk("xor_pass", 8'(pass_v[1]), 8'd1);
    chk("xor_fobs", fo_v[1], 8'h96);

    // NOR: correct run, then both outputs wrong on patterns 1..7.
    pulse_start(2, 2'd0, 2'd0);
    wait_done(2);
    chk("nor_pass", 8'(pass_v[2]), 8'd1);
    chk("nor_fobs", fo_v[2], 8'h01);
    pulse_start(2, 2'd2, 2'd2);
    wait_done(2);
    chk("nor_dbl_err", 8'(err_v[2]), 8'd7);
    chk("nor_dbl_first", 8'(ff_v[2]), 8'd1);
    chk("nor_dbl_fsobs", fso_v[2], 8'hFF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
